// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write scheduler.
// Contents:
//   - widths of the writeback bus and its fields
//   - bit offsets of the fields inside the 20-bit writeback bus
//   - wb_entry_t: one secondary-write buffer entry {valid, rdst, value}
package wb_pkg;

    localparam int WB_DATA_W   = 16;
    localparam int WB_REG_W    = 3;
    localparam int WB_BUS_W    = 20;

    localparam int WB_WE_BIT   = 0;
    localparam int WB_RDST_LSB = 1;
    localparam int WB_VAL_LSB  = 4;

    typedef struct packed {
        logic                 valid;
        logic [WB_REG_W-1:0]  rdst;
        logic [WB_DATA_W-1:0] value;
    } wb_entry_t;

endpackage

// File: rtl/wb_aux_fifo.sv
// Circular buffer for secondary register-file writes.
// Each entry carries a valid bit. A squash request clears the valid bit of
// every live entry whose rdst matches, in parallel. Squashed entries stay in
// the queue and are popped without a write by the consumer.
// Ports:
//   clk, rst       clock; asynchronous active-low reset
//   push           enqueue {push_rdst, push_value} at tail (ignored when full)
//   pop            dequeue head (ignored when empty)
//   squash_en      invalidate entries whose rdst == squash_rdst
//   head           entry at the head of the queue
//   count          occupancy, 0..DEPTH
//   full, empty    occupancy flags
module wb_aux_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WB_REG_W-1:0]  push_rdst,
    input  logic [WB_DATA_W-1:0] push_value,
    input  logic                 pop,
    input  logic                 squash_en,
    input  logic [WB_REG_W-1:0]  squash_rdst,
    output wb_entry_t            head,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 empty
);

    wb_entry_t          mem_q [DEPTH];
    wb_entry_t          mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DEPTH-1:0]   squash_hit;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[head_q];
    assign count   = count_q;

    // One comparator per entry so all matches resolve in the same cycle.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_squash
            assign squash_hit[gi] = squash_en && mem_q[gi].valid &&
                                    (mem_q[gi].rdst == squash_rdst);
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (squash_hit[i]) begin
                mem_d[i].valid = 1'b0;
            end
        end
        // The tail slot is never live when a push is accepted, and the pushed
        // entry is younger than the squashing write, so it is written valid.
        if (push_ok) begin
            mem_d[tail_q] = '{valid: 1'b1, rdst: push_rdst, value: push_value};
        end

        head_d = pop_ok  ? head_q + PTR_W'(1) : head_q;
        tail_d = push_ok ? tail_q + PTR_W'(1) : tail_q;

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_write_scheduler.sv
// Owner of the single register-file write port.
// The writeback stage always wins the port. Secondary writes (second write
// of SWAP, SP update of PUSH/POP) are buffered and drained when the pipeline
// is not writing. A pipeline write squashes older buffered writes to the same
// register. If the head entry waits too long, stall_req freezes the pipeline
// until the buffer is empty.
// Ports:
//   clk, rst       clock; asynchronous active-low reset
//   wb_bus         {value[19:4], rdst[3:1], regwrite[0]} from writeback
//   aux_valid/aux_value/aux_rdst   secondary write request (held by requester)
//   aux_ready      buffer has room (combinational)
//   rf_we/rf_addr/rf_data          registered register-file write port
//   stall_req      registered pipeline freeze request
//   buf_count      buffer occupancy
module wb_write_scheduler
    import wb_pkg::*;
#(
    parameter  int DEPTH      = 2,
    parameter  int STARVE_MAX = 3,
    localparam int CNT_W      = $clog2(DEPTH) + 1,
    localparam int WAIT_W     = $clog2(STARVE_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WB_BUS_W-1:0]  wb_bus,
    input  logic                 aux_valid,
    input  logic [WB_DATA_W-1:0] aux_value,
    input  logic [WB_REG_W-1:0]  aux_rdst,
    output logic                 aux_ready,
    output logic                 rf_we,
    output logic [WB_REG_W-1:0]  rf_addr,
    output logic [WB_DATA_W-1:0] rf_data,
    output logic                 stall_req,
    output logic [CNT_W-1:0]     buf_count
);

    logic                 wb_we;
    logic [WB_REG_W-1:0]  wb_rdst;
    logic [WB_DATA_W-1:0] wb_value;

    wb_entry_t            fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 fifo_push;
    logic                 squash_en;

    logic                 rf_we_q, rf_we_d;
    logic [WB_REG_W-1:0]  rf_addr_q, rf_addr_d;
    logic [WB_DATA_W-1:0] rf_data_q, rf_data_d;
    logic                 stall_q, stall_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 starved;

    assign wb_we    = wb_bus[WB_WE_BIT];
    assign wb_rdst  = wb_bus[WB_RDST_LSB +: WB_REG_W];
    assign wb_value = wb_bus[WB_VAL_LSB +: WB_DATA_W];

    // Readiness uses the pre-edge count: a full buffer refuses a push even
    // when it pops the same edge.
    assign aux_ready = !fifo_full;
    assign fifo_push = aux_valid && aux_ready;

    wb_aux_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (fifo_push),
        .push_rdst   (aux_rdst),
        .push_value  (aux_value),
        .pop         (fifo_pop),
        .squash_en   (squash_en),
        .squash_rdst (wb_rdst),
        .head        (fifo_head),
        .count       (buf_count),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    // Grant: pipeline first, then buffer head. A squashed head is popped
    // with rf_we low; address/data keep their last value.
    always_comb begin
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        fifo_pop  = 1'b0;
        squash_en = 1'b0;
        if (wb_we) begin
            rf_we_d   = 1'b1;
            rf_addr_d = wb_rdst;
            rf_data_d = wb_value;
            squash_en = 1'b1;
        end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            if (fifo_head.valid) begin
                rf_we_d   = 1'b1;
                rf_addr_d = fifo_head.rdst;
                rf_data_d = fifo_head.value;
            end
        end
    end

    // Starvation: count cycles the head loses to the pipeline, saturating.
    // Once the limit is reached the stall holds until the buffer is empty.
    assign starved = (wait_q == WAIT_W'(STARVE_MAX));

    always_comb begin
        wait_d = wait_q;
        if (fifo_empty || fifo_pop) begin
            wait_d = '0;
        end else if (wb_we && !starved) begin
            wait_d = wait_q + WAIT_W'(1);
        end

        stall_d = stall_q;
        if (starved) begin
            stall_d = 1'b1;
        end else if (fifo_empty) begin
            stall_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            stall_q   <= 1'b0;
            wait_q    <= '0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            stall_q   <= stall_d;
            wait_q    <= wait_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_addr   = rf_addr_q;
    assign rf_data   = rf_data_q;
    assign stall_req = stall_q;

endmodule

// File: tb/tb_wb_write_scheduler.sv
// Directed bench for wb_write_scheduler (DEPTH=2, STARVE_MAX=3).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_wb_write_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] wb_bus;
    logic        aux_valid;
    logic [15:0] aux_value;
    logic [2:0]  aux_rdst;
    logic        aux_ready;
    logic        rf_we;
    logic [2:0]  rf_addr;
    logic [15:0] rf_data;
    logic        stall_req;
    logic [1:0]  buf_count;

    int n_checks = 0;
    int n_pass   = 0;

    wb_write_scheduler #(
        .DEPTH      (2),
        .STARVE_MAX (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_bus    (wb_bus),
        .aux_valid (aux_valid),
        .aux_value (aux_value),
        .aux_rdst  (aux_rdst),
        .aux_ready (aux_ready),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .stall_req (stall_req),
        .buf_count (buf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t we=%0b addr=%0d data=%h stall=%0b count=%0d",
                 $time, rf_we, rf_addr, rf_data, stall_req, buf_count);
    endtask

    task automatic set_wb(input logic [15:0] v, input logic [2:0] r, input logic we);
        wb_bus = {v, r, we};
    endtask

    task automatic set_aux(input logic vld, input logic [15:0] v, input logic [2:0] r);
        aux_valid = vld;
        aux_value = v;
        aux_rdst  = r;
    endtask

    task automatic check_write(input string tag, input logic [2:0] a, input logic [15:0] d);
        check({tag, "_we"},   32'(rf_we),   32'd1);
        check({tag, "_addr"}, 32'(rf_addr), 32'(a));
        check({tag, "_data"}, 32'(rf_data), 32'(d));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        set_wb(16'h0, 3'd0, 1'b0);
        set_aux(1'b0, 16'h0, 3'd0);
        tick();
        check("rst_we",    32'(rf_we),     32'd0);
        check("rst_addr",  32'(rf_addr),   32'd0);
        check("rst_data",  32'(rf_data),   32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_count", 32'(buf_count), 32'd0);
        check("rst_ready", 32'(aux_ready), 32'd1);
        rst = 1'b1;

        // Pipeline only
        set_wb(16'hBEEF, 3'd5, 1'b1);
        tick();
        check_write("pipe", 3'd5, 16'hBEEF);
        set_wb(16'h1234, 3'd1, 1'b0);
        tick();
        check("hold_we",   32'(rf_we),   32'd0);
        check("hold_addr", 32'(rf_addr), 32'd5);
        check("hold_data", 32'(rf_data), 32'hBEEF);

        // Priority: pipeline R3 before buffered R2
        set_aux(1'b1, 16'h1111, 3'd2);
        set_wb(16'h2222, 3'd3, 1'b1);
        tick();
        check_write("prio_wb", 3'd3, 16'h2222);
        check("prio_count1", 32'(buf_count), 32'd1);
        set_aux(1'b0, 16'h0, 3'd0);
        set_wb(16'h0, 3'd0, 1'b0);
        tick();
        check_write("prio_aux", 3'd2, 16'h1111);
        check("prio_count0", 32'(buf_count), 32'd0);

        // Fill while the pipeline keeps the port
        set_aux(1'b1, 16'h0101, 3'd1);
        set_wb(16'h7777, 3'd7, 1'b1);
        tick();
        set_aux(1'b1, 16'h0606, 3'd6);
        set_wb(16'h7778, 3'd7, 1'b1);
        tick();
        check("full_count", 32'(buf_count), 32'd2);
        check("full_ready", 32'(aux_ready), 32'd0);
        set_aux(1'b1, 16'h0505, 3'd5);
        set_wb(16'h7779, 3'd7, 1'b1);
        tick();
        check_write("full_wb", 3'd7, 16'h7779);
        check("full_ignored", 32'(buf_count), 32'd2);
        set_wb(16'h0, 3'd0, 1'b0);
        tick();
        check_write("drain1", 3'd1, 16'h0101);
        check("drain1_count", 32'(buf_count), 32'd1);
        tick();
        check_write("drain2", 3'd6, 16'h0606);
        check("pushpop_count", 32'(buf_count), 32'd1);
        set_aux(1'b0, 16'h0, 3'd0);
        tick();
        check_write("drain3", 3'd5, 16'h0505);
        check("drain3_count", 32'(buf_count), 32'd0);
        check("drain_stall", 32'(stall_req), 32'd0);

        // Squash
        set_aux(1'b1, 16'hAAAA, 3'd4);
        tick();
        check("sq_count1", 32'(buf_count), 32'd1);
        set_aux(1'b0, 16'h0, 3'd0);
        set_wb(16'h5555, 3'd4, 1'b1);
        tick();
        check_write("sq_wb", 3'd4, 16'h5555);
        set_wb(16'h0, 3'd0, 1'b0);
        tick();
        check("sq_skip_we",   32'(rf_we),     32'd0);
        check("sq_skip_data", 32'(rf_data),   32'h5555);
        check("sq_count0",    32'(buf_count), 32'd0);
        tick();
        check("sq_after_we",  32'(rf_we),     32'd0);

        // Starvation
        set_aux(1'b1, 16'h6666, 3'd6);
        tick();
        set_aux(1'b0, 16'h0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            set_wb(16'h1000 + 16'(i), 3'd1, 1'b1);
            tick();
            check("starve_low", 32'(stall_req), 32'd0);
        end
        set_wb(16'h1003, 3'd1, 1'b1);
        tick();
        check("starve_high", 32'(stall_req), 32'd1);
        set_wb(16'h1004, 3'd1, 1'b1);
        tick();
        check_write("starve_prio", 3'd1, 16'h1004);
        check("starve_held", 32'(stall_req), 32'd1);
        check("starve_count", 32'(buf_count), 32'd1);
        set_wb(16'h0, 3'd0, 1'b0);
        tick();
        check_write("starve_drain", 3'd6, 16'h6666);
        check("starve_still", 32'(stall_req), 32'd1);
        tick();
        check("starve_clear", 32'(stall_req), 32'd0);
        check("starve_idle",  32'(rf_we),     32'd0);

        // Wrap: continuous push with pop of the previous entry
        for (int i = 0; i < 10; i++) begin
            set_aux(1'b1, 16'hC000 | 16'(i), 3'(i));
            tick();
            if (i == 0) begin
                check("wrap_first_we", 32'(rf_we), 32'd0);
            end else begin
                check_write("wrap", 3'(i - 1), 16'hC000 | 16'(i - 1));
            end
            check("wrap_count", 32'(buf_count), 32'd1);
        end
        set_aux(1'b0, 16'h0, 3'd0);
        tick();
        check_write("wrap_last", 3'd1, 16'hC009);
        check("wrap_empty", 32'(buf_count), 32'd0);

        // Reset in the middle of traffic
        set_aux(1'b1, 16'h1234, 3'd2);
        set_wb(16'h9999, 3'd7, 1'b1);
        tick();
        set_aux(1'b1, 16'h4321, 3'd3);
        tick();
        check("pre_rst_count", 32'(buf_count), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check("arst_we",    32'(rf_we),     32'd0);
        check("arst_addr",  32'(rf_addr),   32'd0);
        check("arst_data",  32'(rf_data),   32'd0);
        check("arst_stall", 32'(stall_req), 32'd0);
        check("arst_count", 32'(buf_count), 32'd0);
        set_aux(1'b0, 16'h0, 3'd0);
        set_wb(16'h0, 3'd0, 1'b0);
        #1;
        rst = 1'b1;
        tick();
        tick();
        check("post_rst_we",    32'(rf_we),     32'd0);
        check("post_rst_count", 32'(buf_count), 32'd0);
        set_aux(1'b1, 16'h3333, 3'd3);
        tick();
        check("post_rst_push_we", 32'(rf_we), 32'd0);
        set_aux(1'b0, 16'h0, 3'd0);
        tick();
        check_write("post_rst_write", 3'd3, 16'h3333);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
